main_memory_responder: RTL and testbench
========================================

// Module: main_memory_responder
// PURPOSE
//   Responder end of the cache-miss memory interface. Accepts line requests from
//   the instruction cache and the data cache, arbitrates round-robin, and serves
//   one request at a time after a fixed latency of LATENCY cycles.
//   Loads return a full line. Stores write a full line and are acknowledged.
//   Sits below both L1 caches as the main-memory model used in the core.
// PARAMETERS
//   LINE_WIDTH  128   bits per line; same as `ICACHE_LINE_WIDTH
//   ADDR_WIDTH  32    request address width
//   MEM_DEPTH   4096  number of lines held (power of 2)
//   LATENCY     10    cycles from acceptance to response; must be >= 2
// PORTS
//   clock         in   1           core clock
//   reset         in   1           asynchronous, active-low reset
//   ic_req_valid  in   1           icache miss request; held high until ic_rsp_valid
//   ic_req_info   in   memory_request_t  {addr, is_store, data}
//   dc_req_valid  in   1           dcache request; held high until dc_rsp_valid
//   dc_req_info   in   memory_request_t  {addr, is_store, data}
//   ic_rsp_valid  out  1           one-cycle response pulse to icache
//   ic_rsp_data   out  LINE_WIDTH  line returned to icache
//   dc_rsp_valid  out  1           one-cycle response pulse to dcache
//   dc_rsp_data   out  LINE_WIDTH  line returned to dcache
//   busy          out  1           high whenever FSM != IDLE
// BEHAVIOUR
// - Reset (reset==0, async):
//   - FSM goes to IDLE.
//   - All outputs are 0.
//   - Priority pointer points to icache.
//   - Latency counter is 0.
//   - Any in-flight transaction is dropped with no response.
//   - The line array is NOT reset; its contents are preserved.
// - Line index = addr[OFF +: log2(MEM_DEPTH)], where OFF = log2(LINE_WIDTH/8).
//   - Offset bits are ignored.
//   - Upper bits alias, so the index wraps modulo MEM_DEPTH.
// - FSM states: IDLE -> WAIT -> RESP -> IDLE.
// - IDLE: if any req_valid is high, accept exactly one request.
//   - If both are valid, the requester named by the priority pointer wins.
//   - Capture requester id, addr, is_store and data.
//   - Load the latency counter, then go to WAIT.
//   - If no request is valid, stay in IDLE.
// - WAIT: counter decrements each cycle. Move to RESP so that rsp_valid rises
//   exactly LATENCY cycles after the acceptance cycle (accept at T -> rsp at T+LATENCY).
// - RESP: lasts one cycle.
//   - Pulse rsp_valid for the captured requester only.
//   - Load: rsp_data = array[index].
//   - Store: write data into array[index] at the end of this cycle; rsp_data = written data.
//   - Priority pointer moves to the other requester. Next state is IDLE.
// - Requests are only sampled in IDLE. Valid held high during WAIT/RESP is ignored.
//   - A requester is never re-accepted in its own RESP cycle.
//   - IDLE samples again one cycle after RESP. The requester drops valid on the edge
//     that closes its RESP cycle, so one request yields exactly one response.
// - Valid dropped before acceptance: no effect.
// - Valid dropped after acceptance: the transaction still completes and responds.
// - is_store is honoured from either port. The icache never sets it.
// - rsp_data is 0 whenever the matching rsp_valid is 0.
// - ic_rsp_valid and dc_rsp_valid are never high in the same cycle.
// - Throughput: one request per LATENCY+1 cycles.
// TESTING
// - Reset check: assert reset low mid-run -> all outputs 0 and busy=0 immediately
//   (asynchronous); preloaded array contents still intact after release.
// - Single load: preload line 0x4 = 128'hA5..A5; ic load addr 0x40 accepted at
//   cycle T -> ic_rsp_valid=1 only at T+10, ic_rsp_data=A5..A5, dc_rsp_valid stays 0.
// - Arbitration: ic and dc both valid in the same cycle after reset -> ic served,
//   rsp at T+10; dc accepted at T+11, rsp at T+21; on the next collision dc wins.
// - Store then load: dc store addr 0x80, data 128'h1234 -> dc ack with data 1234;
//   then ic load addr 0x80 -> ic_rsp_data=1234.
// - Hold and alias: ic valid held 30 cycles with addr = 0x40 + MEM_DEPTH*16
//   -> exactly one ic_rsp_valid pulse, returning line 0x4's data.
// - Reset mid-WAIT: reset low at T+5 of a load -> no rsp pulse ever appears for
//   it; a new request after release responds at acceptance+10.

Source files
------------

// File: rtl/main_memory_responder.sv
// Main-memory model under the L1 caches: round-robin arbitration between icache and
// dcache, one line request in flight, fixed latency from acceptance to response.
package main_memory_responder_pkg;
    localparam int unsigned LINE_WIDTH = 128;
    localparam int unsigned ADDR_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is_store;
        logic [LINE_WIDTH-1:0] data;
    } memory_request_t;
endpackage

module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned LATENCY   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req_valid_i,
    input  memory_request_t       ic_req_info_i,
    input  logic                  dc_req_valid_i,
    input  memory_request_t       dc_req_info_i,
    output logic                  ic_rsp_valid_o,
    output logic [LINE_WIDTH-1:0] ic_rsp_data_o,
    output logic                  dc_rsp_valid_o,
    output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
    output logic                  busy_o
);

    localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY);
    // WAIT lasts LATENCY-1 cycles, counting down to zero
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  prio_q, prio_d;   // 0: icache has priority, 1: dcache
    logic                  id_q, id_d;       // 0: icache, 1: dcache
    logic                  store_q, store_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;

    logic                  ic_rsp_valid_q, ic_rsp_valid_d;
    logic                  dc_rsp_valid_q, dc_rsp_valid_d;
    logic [LINE_WIDTH-1:0] ic_rsp_data_q, ic_rsp_data_d;
    logic [LINE_WIDTH-1:0] dc_rsp_data_q, dc_rsp_data_d;
    logic                  busy_q, busy_d;

    logic [LINE_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [LINE_WIDTH-1:0] rsp_line;

    logic                  grant_dc;
    memory_request_t       req_sel;
    logic                  unused_addr_bits;

    assign grant_dc = dc_req_valid_i && (!ic_req_valid_i || prio_q);
    assign req_sel  = grant_dc ? dc_req_info_i : ic_req_info_i;

    // Offset bits and aliasing upper bits do not select a line
    assign unused_addr_bits = ^{req_sel.addr[ADDR_WIDTH-1:OFF_W+IDX_W], req_sel.addr[OFF_W-1:0]};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            prio_q         <= 1'b0;
            id_q           <= 1'b0;
            store_q        <= 1'b0;
            idx_q          <= '0;
            data_q         <= '0;
            ic_rsp_valid_q <= 1'b0;
            dc_rsp_valid_q <= 1'b0;
            ic_rsp_data_q  <= '0;
            dc_rsp_data_q  <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prio_q         <= prio_d;
            id_q           <= id_d;
            store_q        <= store_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            ic_rsp_valid_q <= ic_rsp_valid_d;
            dc_rsp_valid_q <= dc_rsp_valid_d;
            ic_rsp_data_q  <= ic_rsp_data_d;
            dc_rsp_data_q  <= dc_rsp_data_d;
            busy_q         <= busy_d;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, hand priority over in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        id_d    = id_q;
        store_d = store_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (ic_req_valid_i || dc_req_valid_i) begin
                    id_d    = grant_dc;
                    store_d = req_sel.is_store;
                    idx_d   = req_sel.addr[OFF_W +: IDX_W];
                    data_d  = req_sel.data;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                prio_d  = ~id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs, registered on entry to the state they belong to
    always_comb begin
        ic_rsp_valid_d = 1'b0;
        dc_rsp_valid_d = 1'b0;
        ic_rsp_data_d  = '0;
        dc_rsp_data_d  = '0;
        busy_d         = (state_d != ST_IDLE);
        rsp_line       = store_q ? data_q : mem_q[idx_q];
        if (state_d == ST_RESP) begin
            if (id_q) begin
                dc_rsp_valid_d = 1'b1;
                dc_rsp_data_d  = rsp_line;
            end else begin
                ic_rsp_valid_d = 1'b1;
                ic_rsp_data_d  = rsp_line;
            end
        end
    end

    // Line array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (state_q == ST_RESP && store_q) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign ic_rsp_valid_o = ic_rsp_valid_q;
    assign ic_rsp_data_o  = ic_rsp_data_q;
    assign dc_rsp_valid_o = dc_rsp_valid_q;
    assign dc_rsp_data_o  = dc_rsp_data_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: directed scenarios plus randomized traffic checked
// every cycle against a timeline model (accept at T, respond at T+LATENCY, free at T+LATENCY+1).
module tb_main_memory_responder;
    import main_memory_responder_pkg::*;

    localparam int unsigned LAT    = 10;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned NLINES = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  ic_req_valid, dc_req_valid;
    memory_request_t       ic_req_info, dc_req_info;
    logic                  ic_rsp_valid, dc_rsp_valid, busy;
    logic [LINE_WIDTH-1:0] ic_rsp_data, dc_rsp_data;

    main_memory_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req_valid_i (ic_req_valid),
        .ic_req_info_i  (ic_req_info),
        .dc_req_valid_i (dc_req_valid),
        .dc_req_info_i  (dc_req_info),
        .ic_rsp_valid_o (ic_rsp_valid),
        .ic_rsp_data_o  (ic_rsp_data),
        .dc_rsp_valid_o (dc_rsp_valid),
        .dc_rsp_data_o  (dc_rsp_data),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed, failed, total;
    int cyc;

    // reference model
    logic [LINE_WIDTH-1:0] ref_mem [int];
    bit                    inflight;
    int                    acc_at, rsp_at, free_from, cur_port, prio, cur_line;
    bit                    cur_store;
    logic [LINE_WIDTH-1:0] cur_data;

    // requester side
    bit                    pend [2];
    memory_request_t       pend_req [2];
    int                    rsp_count [2];
    int                    rsp_seen_at [2];
    int                    dut_pulses [2];
    logic [LINE_WIDTH-1:0] dut_last [2];

    function automatic int line_of(input logic [ADDR_WIDTH-1:0] a);
        return int'((a / (LINE_WIDTH / 8)) % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs, input logic [LINE_WIDTH-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) passed++;
        else begin
            failed++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        ic_req_valid = pend[0];
        ic_req_info  = pend_req[0];
        dc_req_valid = pend[1];
        dc_req_info  = pend_req[1];
    endtask

    task automatic req(input int p, input logic [ADDR_WIDTH-1:0] a, input bit st, input logic [LINE_WIDTH-1:0] d);
        pend[p]              = 1'b1;
        pend_req[p].addr     = a;
        pend_req[p].is_store = st;
        pend_req[p].data     = d;
        drive();
    endtask

    // Close the current cycle, then compare every output against the model
    task automatic tick();
        bit                    exp_ic_v, exp_dc_v, exp_busy;
        logic [LINE_WIDTH-1:0] exp_ic_d, exp_dc_d;
        if (rst_n && !inflight && cyc >= free_from && (pend[0] || pend[1])) begin
            cur_port  = (pend[0] && pend[1]) ? prio : (pend[1] ? 1 : 0);
            inflight  = 1'b1;
            acc_at    = cyc;
            rsp_at    = cyc + LAT;
            cur_store = pend_req[cur_port].is_store;
            cur_line  = line_of(pend_req[cur_port].addr);
            cur_data  = cur_store ? pend_req[cur_port].data : ref_mem[cur_line];
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_ic_v = inflight && cyc == rsp_at && cur_port == 0;
        exp_dc_v = inflight && cyc == rsp_at && cur_port == 1;
        exp_busy = inflight && cyc > acc_at && cyc <= rsp_at;
        exp_ic_d = exp_ic_v ? cur_data : '0;
        exp_dc_d = exp_dc_v ? cur_data : '0;
        if (ic_rsp_valid === 1'b1) begin
            dut_pulses[0]++;
            dut_last[0] = ic_rsp_data;
        end
        if (dc_rsp_valid === 1'b1) begin
            dut_pulses[1]++;
            dut_last[1] = dc_rsp_data;
        end
        check("ic_rsp_valid", LINE_WIDTH'(ic_rsp_valid), LINE_WIDTH'(exp_ic_v));
        check("ic_rsp_data", ic_rsp_data, exp_ic_d);
        check("dc_rsp_valid", LINE_WIDTH'(dc_rsp_valid), LINE_WIDTH'(exp_dc_v));
        check("dc_rsp_data", dc_rsp_data, exp_dc_d);
        check("busy", LINE_WIDTH'(busy), LINE_WIDTH'(exp_busy));
        if (inflight && cyc == rsp_at) begin
            if (cur_store) ref_mem[cur_line] = cur_data;
            prio      = 1 - cur_port;
            inflight  = 1'b0;
            free_from = cyc + 1;
            pend[cur_port] = 1'b0;
            rsp_count[cur_port]++;
            rsp_seen_at[cur_port] = cyc;
            drive();
        end
    endtask

    // Wait (bounded) for one DUT response pulse on port p
    task automatic wait_rsp(input int p, input int budget, output int at);
        int start;
        start = dut_pulses[p];
        for (int i = 0; i < budget && dut_pulses[p] == start; i++) tick();
        check_int("rsp_pulse_seen", dut_pulses[p] - start, 1);
        at = cyc;
    endtask

    // Assert reset between edges and check outputs clear without waiting for a clock
    task automatic reset_async();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ic_valid", LINE_WIDTH'(ic_rsp_valid), '0);
        check("rst_ic_data", ic_rsp_data, '0);
        check("rst_dc_valid", LINE_WIDTH'(dc_rsp_valid), '0);
        check("rst_dc_data", dc_rsp_data, '0);
        check("rst_busy", LINE_WIDTH'(busy), '0);
        inflight = 1'b0;
        prio     = 0;
        pend[0]  = 1'b0;
        pend[1]  = 1'b0;
        drive();
        tick();
        tick();
        rst_n     = 1'b1;
        free_from = cyc;
    endtask

    initial begin
        int s, at, p0, line;
        bit st;
        logic [LINE_WIDTH-1:0] a5, d;
        logic [ADDR_WIDTH-1:0] addr;

        passed = 0; failed = 0; total = 0; cyc = 0;
        prio = 0; inflight = 1'b0; free_from = 0;
        acc_at = 0; rsp_at = 0; cur_port = 0; cur_line = 0; cur_store = 1'b0; cur_data = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pend_req[p] = '0; rsp_count[p] = 0;
            rsp_seen_at[p] = 0; dut_pulses[p] = 0; dut_last[p] = '0;
        end
        drive();
        a5    = {16{8'hA5}};
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ic_valid", LINE_WIDTH'(ic_rsp_valid), '0);
        check("reset_ic_data", ic_rsp_data, '0);
        check("reset_dc_valid", LINE_WIDTH'(dc_rsp_valid), '0);
        check("reset_dc_data", dc_rsp_data, '0);
        check("reset_busy", LINE_WIDTH'(busy), '0);
        rst_n     = 1'b1;
        free_from = cyc;

        // preload lines 0..7 through dcache stores; line 4 holds A5..A5
        for (int l = 0; l < NLINES; l++) begin
            d = (l == 4) ? a5 : {$urandom, $urandom, $urandom, $urandom};
            s = cyc;
            req(1, ADDR_WIDTH'(l * 16), 1'b1, d);
            wait_rsp(1, 40, at);
            check_int("store_latency", at - s, 10);
            check("store_ack_data", dc_rsp_data, d);
            tick();
        end

        // single icache load of line 4
        s = cyc;
        req(0, 32'h40, 1'b0, '0);
        wait_rsp(0, 40, at);
        check_int("load_latency", at - s, 10);
        check("load_data", ic_rsp_data, a5);
        check("load_dc_quiet", LINE_WIDTH'(dc_rsp_valid), '0);
        tick();

        // store then load through the other port
        req(1, 32'h80, 1'b1, 128'h1234);
        wait_rsp(1, 40, at);
        check("store_ack", dc_rsp_data, 128'h1234);
        tick();
        req(0, 32'h80, 1'b0, '0);
        wait_rsp(0, 40, at);
        check("store_then_load", ic_rsp_data, 128'h1234);
        tick();

        // reset in the middle of WAIT drops the load silently
        req(0, 32'h40, 1'b0, '0);
        repeat (5) tick();
        check("busy_in_wait", LINE_WIDTH'(busy), LINE_WIDTH'(1'b1));
        p0 = dut_pulses[0];
        reset_async();
        repeat (20) tick();
        check_int("no_rsp_after_reset", dut_pulses[0] - p0, 0);

        // collision after reset: icache first, then dcache wins the next collision
        s = cyc;
        req(0, 32'h40, 1'b0, '0);
        req(1, 32'h80, 1'b0, '0);
        wait_rsp(0, 40, at);
        check_int("arb_ic_first", at - s, 10);
        check("arb_ic_data", ic_rsp_data, a5);
        req(0, 32'h44, 1'b0, '0);
        wait_rsp(1, 40, at);
        check_int("arb_dc_second", at - s, 21);
        check("arb_dc_data", dc_rsp_data, 128'h1234);
        wait_rsp(0, 40, at);
        check_int("arb_ic_third", at - s, 32);
        check("arb_ic_offset_ignored", ic_rsp_data, a5);
        tick();

        // valid held with an aliased address: one pulse, line 4 data
        p0 = dut_pulses[0];
        req(0, ADDR_WIDTH'(32'h40 + DEPTH * 16), 1'b0, '0);
        repeat (30) tick();
        check_int("hold_one_pulse", dut_pulses[0] - p0, 1);
        check("alias_data", dut_last[0], a5);

        // reset while a response is on the bus clears it at once
        req(0, 32'h80, 1'b0, '0);
        wait_rsp(0, 40, at);
        check("rsp_before_reset", LINE_WIDTH'(ic_rsp_valid), LINE_WIDTH'(1'b1));
        reset_async();
        s = cyc;
        req(0, 32'h40, 1'b0, '0);
        wait_rsp(0, 40, at);
        check_int("post_reset_latency", at - s, 10);
        check("post_reset_array_kept", ic_rsp_data, a5);

        // randomized traffic on both ports, including withdrawals before acceptance
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    line = $urandom_range(0, NLINES - 1);
                    addr = ADDR_WIDTH'($urandom_range(0, 65535)) * ADDR_WIDTH'(DEPTH * 16)
                         + ADDR_WIDTH'(line * 16) + ADDR_WIDTH'($urandom_range(0, 15));
                    st   = (p == 1) && ($urandom_range(0, 1) == 1);
                    d    = {$urandom, $urandom, $urandom, $urandom};
                    req(p, addr, st, d);
                end else if (pend[p] && !(inflight && cur_port == p) && $urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                    drive();
                end
            end
            tick();
        end
        for (int i = 0; i < 60 && (pend[0] || pend[1] || inflight); i++) tick();
        tick();
        check("final_idle", LINE_WIDTH'(busy), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
